small_buffer_arbiter: RTL and testbench
=======================================

Name: small_buffer_arbiter

Overview:
- Shares one small buffer / bf16 multiply-tree datapath between two 256-bit line producers (requester 0, requester 1).
- The buffer runs fixed fill windows of DEPTH back-to-back write cycles, then a calculate phase. This block aligns to those windows and grants each whole window to one requester, round-robin.
- It muxes the granted requester's mode and lines-per-node configuration to the buffer, then tags the multiply-tree results and max-exponent pulses with the owning requester.

Parameters:
- DEPTH, 256, lines per fill window; equals the buffer depth.
- LOG2_DEPTH, 8, width of the window beat counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_data[0:1]  in  2x256  line data per requester
- req_vld[0:1]  in  2x1  requester valid
- req_ready[0:1]  out  2x1  beat accepted (valid&ready)
- req_mode[0:1]  in  2x2  mul-tree mode per requester
- req_lines_m1[0:1]  in  2x11  lines per node minus one, per requester
- buf_in_data  out  256  to buffer interface_in
- buf_in_vld  out  1  to buffer input_vld
- buf_in_ready  in  1  buffer input_ready (high = fill window)
- buf_mode  out  2  to buffer mode
- buf_lines_m1  out  11  to buffer num_of_line_per_node_minusone
- buf_out_data  in  64  multiply-tree result
- buf_out_vld  in  1  result valid
- buf_max_exp  in  8  buffer max exponent
- buf_max_exp_vld  in  1  max exponent pulse
- res_data  out  64  tagged result
- res_vld  out  1  result valid for res_owner
- res_owner  out  1  requester owning results
- max_exp  out  8  forwarded max exponent
- max_exp_vld  out  1  forwarded pulse (owned fills only)
- underrun  out  2  sticky per-requester: valid dropped mid-window
- busy  out  1  a fill window is owned by a requester

Behaviour:
- Reset values (async):
  - FSM = WAIT, beat_cnt = 0, last_grant = 1 (so requester 0 wins first).
  - fill_owner_vld = 0, res_owner = 0, res_owner_vld = 0.
  - underrun = 0, and every output = 0.
- States:
  - WAIT: buffer in calculate phase.
  - WIN0: first cycle of a window.
  - FILL: remaining window cycles.
- Transitions:
  - WAIT -> WIN0 when buf_in_ready = 1. This includes the first cycle after reset, because the buffer resets into its fill window.
  - WIN0 -> FILL unconditionally.
  - FILL -> WAIT when beat_cnt == DEPTH-1.
- beat_cnt: increments every window cycle and clears at DEPTH-1. The buffer advances its write address every cycle regardless of valid, so the window length is exactly DEPTH cycles and never stalls.
- Grant, decided combinationally in WIN0 and registered for the rest of the window:
  - Both requesters valid: grant !last_grant.
  - One requester valid: grant that requester.
  - Neither valid: unowned window.
  - last_grant updates only on an owned grant.
- Owned window:
  - req_ready[g] = 1 for all DEPTH cycles; the other requester's ready = 0.
  - buf_in_data = req_data[g]; buf_in_vld = req_vld[g].
  - If req_vld[g] = 0 during FILL: buf_in_data = 0, underrun[g] is set, and the window is not extended.
- Unowned window: buf_in_data = 0, buf_in_vld = 0, all ready = 0.
- buf_mode / buf_lines_m1:
  - Driven from res_owner's configuration and updated only at window end.
  - Combinationally muxed from fill_owner in WIN0 only if res_owner_vld = 0.
- Window end (FILL, beat_cnt == DEPTH-1): res_owner <= fill_owner; res_owner_vld <= owned.
- Result forwarding:
  - res_data = buf_out_data; res_vld = buf_out_vld & res_owner_vld.
  - max_exp_vld = buf_max_exp_vld & res_owner_vld; max_exp = buf_max_exp. This path is combinational, zero latency.
  - Multiply-tree latency < DEPTH is required, so trailing results complete before res_owner changes.
- busy = fill_owner_vld during WIN0/FILL, else 0.
- Reset mid-window: all state clears immediately. The buffer is reset by the same rst, so both stay aligned.

Optional Feature:
- SMALL_ARB_FILL_CNT_EN.
- Defined: adds output fill_cnt (2x16), a per-requester saturating count of completed owned windows. It increments at window end, holds at 16'hFFFF, and clears on rst.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header:
  - FSM state encodings WAIT / WIN0 / FILL.
  - Requester ID width.
  - Defaults tied to the existing small_bram_depth_in / small_log2_bram_depth_in defines.
- One natural sub-module: rr_arb2, a two-input round-robin grant with last-grant register.

Test Plan:
- Reset, req0 valid continuously, DEPTH=256:
  - req_ready[0] high exactly 256 cycles; then buf_in_ready low.
  - Results carry res_owner = 0, res_vld tracks buf_out_vld.
- Both requesters valid every window:
  - Grants alternate 0, 1, 0, 1 across four windows.
  - max_exp_vld owners follow the same order.
- Neither valid at WIN0, req1 valid from cycle 5:
  - Window unowned, req_ready[1] = 0 for the whole window.
  - No res_vld / max_exp_vld for that window.
  - req1 granted in the next window.
- req0 granted, valid dropped for cycles 100–102:
  - buf_in_data = 0 on those cycles, underrun = 2'b01.
  - Window still ends at cycle 255.
- rst asserted at window cycle 130:
  - All outputs 0 immediately.
  - The next window starts on the first cycle after rst deasserts, with req0 winning.
- With SMALL_ARB_FILL_CNT_EN, 3 owned req1 windows: fill_cnt[1] = 3, fill_cnt[0] = 0.

Source files
------------

// File: rtl/small_buffer_arbiter_pkg.sv
// Shared types and defaults for small_buffer_arbiter.
// Depth defaults follow the SMALL_BRAM_DEPTH_IN / SMALL_LOG2_BRAM_DEPTH_IN defines.
`ifndef SMALL_BRAM_DEPTH_IN
`define SMALL_BRAM_DEPTH_IN 256
`endif
`ifndef SMALL_LOG2_BRAM_DEPTH_IN
`define SMALL_LOG2_BRAM_DEPTH_IN 8
`endif

package small_buffer_arbiter_pkg;
  localparam int unsigned SBA_DEPTH      = `SMALL_BRAM_DEPTH_IN;
  localparam int unsigned SBA_LOG2_DEPTH = `SMALL_LOG2_BRAM_DEPTH_IN;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned REQ_ID_W = 1;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned RES_W    = 64;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned MODE_W   = 2;
  localparam int unsigned LINES_W  = 11;
  localparam int unsigned FCNT_W   = 16;

  typedef logic [REQ_ID_W-1:0] req_id_t;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_WIN0 = 2'd1,
    S_FILL = 2'd2
  } win_state_t;
endpackage

// File: rtl/small_buffer_arbiter_if.sv
// Requester and buffer-side bus for small_buffer_arbiter.
// master = producers + buffer environment, slave = the arbiter.
interface small_buffer_arbiter_if;
  import small_buffer_arbiter_pkg::*;

  logic [NUM_REQ-1:0][LINE_W-1:0]  req_data;
  logic [NUM_REQ-1:0]              req_vld;
  logic [NUM_REQ-1:0]              req_ready;
  logic [NUM_REQ-1:0][MODE_W-1:0]  req_mode;
  logic [NUM_REQ-1:0][LINES_W-1:0] req_lines_m1;

  logic [LINE_W-1:0]  buf_in_data;
  logic               buf_in_vld;
  logic               buf_in_ready;
  logic [MODE_W-1:0]  buf_mode;
  logic [LINES_W-1:0] buf_lines_m1;
  logic [RES_W-1:0]   buf_out_data;
  logic               buf_out_vld;
  logic [EXP_W-1:0]   buf_max_exp;
  logic               buf_max_exp_vld;

  modport master (
    output req_data, req_vld, req_mode, req_lines_m1,
    output buf_in_ready, buf_out_data, buf_out_vld, buf_max_exp, buf_max_exp_vld,
    input  req_ready, buf_in_data, buf_in_vld, buf_mode, buf_lines_m1
  );

  modport slave (
    input  req_data, req_vld, req_mode, req_lines_m1,
    input  buf_in_ready, buf_out_data, buf_out_vld, buf_max_exp, buf_max_exp_vld,
    output req_ready, buf_in_data, buf_in_vld, buf_mode, buf_lines_m1
  );
endinterface

// File: rtl/small_buffer_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant resets to 1 so requester 0 wins first.
module rr_arb2
  import small_buffer_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       decide,
  output logic       gnt_vld,
  output req_id_t    gnt
);
  req_id_t last_grant;

  always_comb begin
    gnt_vld = |req;
    gnt     = '0;
    if (&req)        gnt = ~last_grant;
    else if (req[1]) gnt = req_id_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    last_grant <= req_id_t'(1);
    else if (decide && gnt_vld) last_grant <= gnt;
  end
endmodule

// File: rtl/small_buffer_arbiter.sv
// Grants whole buffer fill windows to one of two line producers and tags results.
// Optional SMALL_ARB_FILL_CNT_EN adds per-requester saturating owned-window counters.
module small_buffer_arbiter
  import small_buffer_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH      = SBA_DEPTH,
  parameter int unsigned LOG2_DEPTH = SBA_LOG2_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  small_buffer_arbiter_if.slave bus,
  output logic [RES_W-1:0]      res_data,
  output logic                  res_vld,
  output req_id_t               res_owner,
  output logic [EXP_W-1:0]      max_exp,
  output logic                  max_exp_vld,
  output logic [NUM_REQ-1:0]    underrun,
  output logic                  busy
`ifdef SMALL_ARB_FILL_CNT_EN
  ,
  output logic [NUM_REQ-1:0][FCNT_W-1:0] fill_cnt
`endif
);
  win_state_t          state_q, state_d;
  logic [LOG2_DEPTH-1:0] beat_cnt;
  logic                win_last;
  logic                gnt_vld;
  req_id_t             gnt;
  logic                fill_owner_vld;
  req_id_t             fill_owner;
  logic                res_owner_vld;
  logic                own_vld;
  req_id_t             own;
  logic [MODE_W-1:0]   mode_q;
  logic [LINES_W-1:0]  lines_q;

  assign win_last = (state_q == S_FILL) && (beat_cnt == LOG2_DEPTH'(DEPTH - 1));

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_vld),
    .decide  (state_q == S_WIN0),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  // The grant is live in WIN0 and taken from the registered owner for the rest of the window.
  always_comb begin
    state_d          = state_q;
    own_vld          = 1'b0;
    own              = '0;
    bus.req_ready    = '0;
    bus.buf_in_data  = '0;
    bus.buf_in_vld   = 1'b0;
    bus.buf_mode     = mode_q;
    bus.buf_lines_m1 = lines_q;
    unique case (state_q)
      S_WAIT: if (bus.buf_in_ready) state_d = S_WIN0;
      S_WIN0: begin
        state_d = S_FILL;
        own_vld = gnt_vld;
        own     = gnt;
        if (gnt_vld && !res_owner_vld) begin
          bus.buf_mode     = bus.req_mode[gnt];
          bus.buf_lines_m1 = bus.req_lines_m1[gnt];
        end
      end
      S_FILL: begin
        own_vld = fill_owner_vld;
        own     = fill_owner;
        if (win_last) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
    if (own_vld) begin
      bus.req_ready[own] = 1'b1;
      bus.buf_in_vld     = bus.req_vld[own];
      if (bus.req_vld[own]) bus.buf_in_data = bus.req_data[own];
    end
    busy = own_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_WAIT;
      beat_cnt       <= '0;
      fill_owner_vld <= 1'b0;
      fill_owner     <= '0;
      res_owner      <= '0;
      res_owner_vld  <= 1'b0;
      underrun       <= '0;
      mode_q         <= '0;
      lines_q        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != S_WAIT) beat_cnt <= win_last ? '0 : beat_cnt + 1'b1;
      if (state_q == S_WIN0) begin
        fill_owner_vld <= gnt_vld;
        if (gnt_vld) fill_owner <= gnt;
      end
      if (state_q == S_FILL && own_vld && !bus.req_vld[own]) underrun[own] <= 1'b1;
      if (win_last) begin
        res_owner      <= fill_owner;
        res_owner_vld  <= fill_owner_vld;
        fill_owner_vld <= 1'b0;
        if (fill_owner_vld) begin
          mode_q  <= bus.req_mode[fill_owner];
          lines_q <= bus.req_lines_m1[fill_owner];
        end
      end
    end
  end

  assign res_data    = bus.buf_out_data;
  assign res_vld     = bus.buf_out_vld & res_owner_vld;
  assign max_exp     = bus.buf_max_exp;
  assign max_exp_vld = bus.buf_max_exp_vld & res_owner_vld;

`ifdef SMALL_ARB_FILL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
    end else if (win_last && fill_owner_vld && (fill_cnt[fill_owner] != '1)) begin
      fill_cnt[fill_owner] <= fill_cnt[fill_owner] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_small_buffer_arbiter.sv
// Directed self-checking bench for small_buffer_arbiter (DEPTH = 256).
module tb_small_buffer_arbiter;
  logic        clk;
  logic        rst;
  logic [63:0] res_data;
  logic        res_vld;
  logic [0:0]  res_owner;
  logic [7:0]  max_exp;
  logic        max_exp_vld;
  logic [1:0]  underrun;
  logic        busy;
`ifdef SMALL_ARB_FILL_CNT_EN
  logic [1:0][15:0] fill_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  small_buffer_arbiter_if bus();

  small_buffer_arbiter #(.DEPTH(256), .LOG2_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .res_data    (res_data),
    .res_vld     (res_vld),
    .res_owner   (res_owner),
    .max_exp     (max_exp),
    .max_exp_vld (max_exp_vld),
    .underrun    (underrun),
    .busy        (busy)
`ifdef SMALL_ARB_FILL_CNT_EN
    ,
    .fill_cnt    (fill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One fill window: k=-1 is the WAIT cycle that sees buf_in_ready, k=0 is WIN0, k=255 the last FILL.
  task automatic run_window(input bit v0, input bit v1, input int v1_from,
                            input int drop_lo, input int drop_hi, input int rst_at,
                            input int exp_owner, input bit chk_cfg,
                            input logic [1:0] exp_mode, input logic [10:0] exp_lines,
                            input string tag);
    logic [1:0]        vv;
    logic [1:0][255:0] dd;
    logic [1:0]        exp_rdy;
    logic [255:0]      exp_d;
    logic              exp_v;
    bit                owned;
    int                eo;
    int rdy0 = 0, rdy1 = 0, bad_d = 0, bad_v = 0, bad_b = 0, bad_r = 0, bad_idle = 0;
    int nk;
    owned = (exp_owner >= 0);
    eo    = (exp_owner == 1) ? 1 : 0;
    nk    = (rst_at < 256) ? rst_at : 256;
    for (int k = -1; k < 256; k++) begin
      @(negedge clk);
      if (k == -1) rst = 1'b0;
      if (k == rst_at) begin
        rst = 1'b1;
        bus.buf_out_vld = 1'b1;
        bus.buf_max_exp_vld = 1'b1;
        #1;
        check({tag, ".rst_ready"}, bus.req_ready, 2'b00);
        check({tag, ".rst_busy"}, busy, 1'b0);
        check({tag, ".rst_in_vld"}, bus.buf_in_vld, 1'b0);
        check({tag, ".rst_in_data"}, bus.buf_in_data, '0);
        check({tag, ".rst_underrun"}, underrun, 2'b00);
        check({tag, ".rst_res_vld"}, res_vld, 1'b0);
        check({tag, ".rst_max_exp_vld"}, max_exp_vld, 1'b0);
        check({tag, ".rst_res_owner"}, res_owner, 1'b0);
        check({tag, ".rst_mode"}, bus.buf_mode, 2'b00);
        check({tag, ".rst_lines"}, bus.buf_lines_m1, 11'h000);
        check({tag, ".rst_rdy_cnt"}, eo ? rdy1 : rdy0, nk);
        bus.buf_out_vld = 1'b0;
        bus.buf_max_exp_vld = 1'b0;
        bus.buf_in_ready = 1'b0;
        bus.req_vld = 2'b00;
        return;
      end
      bus.buf_in_ready = 1'b1;
      vv[0] = v0 && !(k >= drop_lo && k <= drop_hi);
      vv[1] = v1 && (k >= v1_from);
      dd[0] = {8{32'hA000_0000 | 32'(k + 2)}};
      dd[1] = {8{32'hB100_0000 | 32'(k + 2)}};
      bus.req_vld  = vv;
      bus.req_data = dd;
      #1;
      if (k < 0) begin
        if (bus.req_ready !== 2'b00 || busy !== 1'b0) bad_idle++;
      end else begin
        exp_rdy = owned ? (2'b01 << eo) : 2'b00;
        exp_v   = owned && vv[eo];
        exp_d   = exp_v ? dd[eo] : '0;
        if (bus.req_ready !== exp_rdy) bad_r++;
        if (bus.buf_in_vld !== exp_v) bad_v++;
        if (bus.buf_in_data !== exp_d) bad_d++;
        if (busy !== owned) bad_b++;
        rdy0 += int'(bus.req_ready[0]);
        rdy1 += int'(bus.req_ready[1]);
        if (k == 0 && chk_cfg) begin
          check({tag, ".win0_mode"}, bus.buf_mode, exp_mode);
          check({tag, ".win0_lines"}, bus.buf_lines_m1, exp_lines);
        end
      end
    end
    check({tag, ".rdy0_cnt"}, rdy0, (owned && eo == 0) ? 256 : 0);
    check({tag, ".rdy1_cnt"}, rdy1, (owned && eo == 1) ? 256 : 0);
    check({tag, ".ready_bad"}, bad_r, 0);
    check({tag, ".in_vld_bad"}, bad_v, 0);
    check({tag, ".in_data_bad"}, bad_d, 0);
    check({tag, ".busy_bad"}, bad_b, 0);
    check({tag, ".wait_idle_bad"}, bad_idle, 0);
  endtask

  // Calculate phase: buffer not ready, one result and one max-exponent pulse.
  task automatic gap(input bit exp_vld, input logic exp_owner, input logic [1:0] exp_mode,
                     input logic [10:0] exp_lines, input logic [1:0] exp_underrun,
                     input logic [63:0] rd, input string tag);
    @(negedge clk);
    bus.buf_in_ready = 1'b0;
    bus.req_vld = 2'b00;
    #1;
    check({tag, ".gap_busy"}, busy, 1'b0);
    check({tag, ".gap_ready"}, bus.req_ready, 2'b00);
    check({tag, ".underrun"}, underrun, exp_underrun);
    @(negedge clk);
    bus.buf_out_vld = 1'b1;
    bus.buf_out_data = rd;
    bus.buf_max_exp = 8'h5A;
    bus.buf_max_exp_vld = 1'b1;
    #1;
    check({tag, ".res_vld"}, res_vld, exp_vld);
    check({tag, ".max_exp_vld"}, max_exp_vld, exp_vld);
    check({tag, ".res_data"}, res_data, rd);
    check({tag, ".max_exp"}, max_exp, 8'h5A);
    if (exp_vld) begin
      check({tag, ".res_owner"}, res_owner, exp_owner);
      check({tag, ".buf_mode"}, bus.buf_mode, exp_mode);
      check({tag, ".buf_lines"}, bus.buf_lines_m1, exp_lines);
    end
    @(negedge clk);
    bus.buf_out_vld = 1'b0;
    bus.buf_out_data = '0;
    bus.buf_max_exp = '0;
    bus.buf_max_exp_vld = 1'b0;
    #1;
    check({tag, ".res_vld_off"}, res_vld, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_data = '0;
    bus.req_vld = 2'b00;
    bus.req_mode = {2'b01, 2'b10};
    bus.req_lines_m1 = {11'h2AB, 11'h123};
    bus.buf_in_ready = 1'b0;
    bus.buf_out_data = '0;
    bus.buf_out_vld = 1'b0;
    bus.buf_max_exp = '0;
    bus.buf_max_exp_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset.ready", bus.req_ready, 2'b00);
    check("reset.busy", busy, 1'b0);
    check("reset.in_vld", bus.buf_in_vld, 1'b0);
    check("reset.underrun", underrun, 2'b00);
    check("reset.res_owner", res_owner, 1'b0);
    check("reset.mode", bus.buf_mode, 2'b00);

    // req0 alone, config muxed live in WIN0 since no result owner yet
    run_window(1, 0, 0, 1000, -1, 1000, 0, 1, 2'b10, 11'h123, "w1_req0");
    gap(1, 1'b0, 2'b10, 11'h123, 2'b00, 64'h1111_2222_3333_4444, "g1");

    // req0 drops valid on cycles 100..102
    run_window(1, 0, 0, 100, 102, 1000, 0, 0, 2'b00, 11'h000, "w2_drop");
    gap(1, 1'b0, 2'b10, 11'h123, 2'b01, 64'h0000_0000_0000_00AB, "g2");

    // both valid after a req0 grant -> req1; reset lands on window cycle 130
    run_window(1, 1, 0, 1000, -1, 130, 1, 0, 2'b00, 11'h000, "w3_rst");
    repeat (2) @(negedge clk);

    // after reset both valid: 0,1,0,1
    run_window(1, 1, 0, 1000, -1, 1000, 0, 1, 2'b10, 11'h123, "alt0");
    gap(1, 1'b0, 2'b10, 11'h123, 2'b00, 64'hA0, "ga0");
    run_window(1, 1, 0, 1000, -1, 1000, 1, 0, 2'b00, 11'h000, "alt1");
    gap(1, 1'b1, 2'b01, 11'h2AB, 2'b00, 64'hA1, "ga1");
    run_window(1, 1, 0, 1000, -1, 1000, 0, 0, 2'b00, 11'h000, "alt2");
    gap(1, 1'b0, 2'b10, 11'h123, 2'b00, 64'hA2, "ga2");
    run_window(1, 1, 0, 1000, -1, 1000, 1, 0, 2'b00, 11'h000, "alt3");
    gap(1, 1'b1, 2'b01, 11'h2AB, 2'b00, 64'hA3, "ga3");

    // nobody valid at WIN0, req1 arrives on cycle 5: unowned window, then req1
    run_window(0, 1, 5, 1000, -1, 1000, -1, 0, 2'b00, 11'h000, "unowned");
    gap(0, 1'b0, 2'b00, 11'h000, 2'b00, 64'hBEEF, "gu");
    run_window(0, 1, 0, 1000, -1, 1000, 1, 1, 2'b01, 11'h2AB, "req1_next");
    gap(1, 1'b1, 2'b01, 11'h2AB, 2'b00, 64'hC0FFEE, "gn");

`ifdef SMALL_ARB_FILL_CNT_EN
    check("fcnt.pre0", fill_cnt[0], 16'd2);
    check("fcnt.pre1", fill_cnt[1], 16'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("fcnt.rst", fill_cnt, '0);
    repeat (2) @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      run_window(0, 1, 0, 1000, -1, 1000, 1, 0, 2'b00, 11'h000, "fc_req1");
      gap(1, 1'b1, 2'b01, 11'h2AB, 2'b00, 64'hF0, "gfc");
    end
    check("fcnt.req0", fill_cnt[0], 16'd0);
    check("fcnt.req1", fill_cnt[1], 16'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
